// File: rtl/cdb_rsv_issue_queue.sv
// Reservation-station issue queue for one functional unit: holds dispatched instructions,
// wakes source operands from CDB broadcasts and presents the oldest ready entry for issue.
module cdb_rsv_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OP_W   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       flush,
    input  logic                       dispatch_en,
    input  logic [OP_W-1:0]            dispatch_op,
    input  logic [TAG_W-1:0]           dispatch_rd_tag,
    input  logic [TAG_W-1:0]           dispatch_rs1_tag,
    input  logic [DATA_W-1:0]          dispatch_rs1_data,
    input  logic                       dispatch_rs1_rdy,
    input  logic [TAG_W-1:0]           dispatch_rs2_tag,
    input  logic [DATA_W-1:0]          dispatch_rs2_data,
    input  logic                       dispatch_rs2_rdy,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       ready_out,
    input  logic                       issue_done,
    output logic [OP_W-1:0]            issue_op,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [DATA_W-1:0]          issue_rs1_data,
    output logic [DATA_W-1:0]          issue_rs2_data
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd_tag;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
        logic              rs2_rdy;
    } entry_t;

    // Entries are compacted: slots 0..count-1 are valid, slot 0 is the oldest.
    entry_t         q      [DEPTH];
    entry_t         snoop  [DEPTH];
    entry_t         q_nxt  [DEPTH];
    entry_t         disp_e;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [CW-1:0]  sel_idx;
    logic [CW-1:0]  wr_idx;
    logic           any_rdy;
    logic           retire;
    logic           disp_ok;

    // Handshake: ready_out is the valid, issue_done the ready; an entry retires only
    // at an edge where both are high, and the grant is ignored while ready_out is low.
    assign o_full    = (count == CW'(DEPTH));
    assign o_count   = count;
    assign ready_out = any_rdy;
    assign retire    = issue_done & any_rdy;
    assign disp_ok   = dispatch_en & ~o_full;
    assign wr_idx    = count - CW'(retire);
    assign count_nxt = count + CW'(disp_ok) - CW'(retire);

    // Selection looks at registered readiness only, so a CDB wake shows up a cycle later.
    always_comb begin
        any_rdy = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_rdy && (CW'(i) < count) && q[i].rs1_rdy && q[i].rs2_rdy) begin
                any_rdy = 1'b1;
                sel_idx = CW'(i);
            end
        end
    end

    always_comb begin
        issue_op       = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (any_rdy && (CW'(i) == sel_idx)) begin
                issue_op       = q[i].op;
                issue_rd_tag   = q[i].rd_tag;
                issue_rs1_data = q[i].rs1_data;
                issue_rs2_data = q[i].rs2_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop[i] = q[i];
            if (cdb_valid && !q[i].rs1_rdy && (q[i].rs1_tag == cdb_tag)) begin
                snoop[i].rs1_data = cdb_data;
                snoop[i].rs1_rdy  = 1'b1;
            end
            if (cdb_valid && !q[i].rs2_rdy && (q[i].rs2_tag == cdb_tag)) begin
                snoop[i].rs2_data = cdb_data;
                snoop[i].rs2_rdy  = 1'b1;
            end
        end
    end

    always_comb begin
        disp_e.op       = dispatch_op;
        disp_e.rd_tag   = dispatch_rd_tag;
        disp_e.rs1_tag  = dispatch_rs1_tag;
        disp_e.rs1_data = dispatch_rs1_data;
        disp_e.rs1_rdy  = dispatch_rs1_rdy;
        disp_e.rs2_tag  = dispatch_rs2_tag;
        disp_e.rs2_data = dispatch_rs2_data;
        disp_e.rs2_rdy  = dispatch_rs2_rdy;
        if (cdb_valid && !dispatch_rs1_rdy && (dispatch_rs1_tag == cdb_tag)) begin
            disp_e.rs1_data = cdb_data;
            disp_e.rs1_rdy  = 1'b1;
        end
        if (cdb_valid && !dispatch_rs2_rdy && (dispatch_rs2_tag == cdb_tag)) begin
            disp_e.rs2_data = cdb_data;
            disp_e.rs2_rdy  = 1'b1;
        end
    end

    // Compaction acts on the snooped copy so a wake in the retire cycle moves with its entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = snoop[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (retire && (CW'(i) >= sel_idx)) begin
                q_nxt[i] = snoop[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_ok && (CW'(i) == wr_idx)) begin
                q_nxt[i] = disp_e;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // Slots at or above count are dead, so the payload needs no reset.
    always_ff @(posedge i_clk) begin
        q <= q_nxt;
    end

endmodule
